// File: rtl/ufm_arbiter.sv
// ufm_arbiter: round-robin sharing of one ufm_reader between two requesters.
// Each grant is one page burst of PAGE_BYTES strobes. Build option
// UFM_ARB_TIMEOUT_EN adds a TIMEOUT parameter and a sticky err output that
// aborts a burst whose reader has gone silent.
module ufm_arbiter #(
  parameter int PAGE_BYTES = 16,
  parameter int ADDR_W     = 11
`ifdef UFM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT  = 4096
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              stall0,
  output logic              gnt0,
  output logic              stb0,
  output logic              done0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              stall1,
  output logic              gnt1,
  output logic              stb1,
  output logic              done1,
  output logic [7:0]        data,
  output logic              busy,
`ifdef UFM_ARB_TIMEOUT_EN
  output logic              err,
`endif
  output logic              ufm_start,
  output logic [ADDR_W-1:0] ufm_addr,
  output logic              ufm_stall,
  input  logic [7:0]        ufm_data,
  input  logic              ufm_data_stb,
  input  logic              ufm_ready
);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  // One extra bit so the terminal compare at PAGE_BYTES-1 never wraps.
  localparam int CW = $clog2(PAGE_BYTES) + 1;
  localparam logic [CW-1:0] LAST = CW'(PAGE_BYTES - 1);

  state_t        state, state_nx;
  logic [CW-1:0] count;
  logic          owner;
  logic          rr_last;
  logic          win;
  logic          grant;
  logic          burst_stb;
  logic          last_stb;
  logic          to_hit;

`ifdef UFM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tcnt;

  // Silent-reader watchdog: cleared by strobes, frozen while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      if (state != BURST || ufm_data_stb)
        tcnt <= '0;
      else if (!ufm_stall)
        tcnt <= tcnt + 1'b1;
      if (to_hit)
        err <= 1'b1;
    end
  end
`endif

  // Winner selection and qualified burst strobes.
  always_comb begin
    win = 1'b0;
    if (req0 && req1)
      win = ~rr_last;
    else
      win = req1;
    grant     = (state == IDLE) && ufm_ready && (req0 || req1);
    burst_stb = (state == BURST) && ufm_data_stb;
    last_stb  = burst_stb && (count == LAST);
`ifdef UFM_ARB_TIMEOUT_EN
    to_hit = (state == BURST) && !ufm_data_stb && !ufm_stall && (tcnt == TO_LAST);
`else
    to_hit = 1'b0;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant) state_nx = BURST;
      BURST:   if (last_stb || to_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Grant bookkeeping, reader start pulse/address and byte counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= 1'b0;
      rr_last   <= 1'b1;
      count     <= '0;
      ufm_addr  <= '0;
      ufm_start <= 1'b0;
    end else begin
      ufm_start <= grant;
      if (grant) begin
        owner    <= win;
        rr_last  <= win;
        ufm_addr <= win ? addr1 : addr0;
        count    <= '0;
      end else if (burst_stb) begin
        count <= count + 1'b1;
      end
    end
  end

  // Outputs decoded from state and owner; strobes are routed combinationally.
  always_comb begin
    busy      = (state != IDLE);
    gnt0      = busy && !owner;
    gnt1      = busy && owner;
    done0     = (state == DONE) && !owner;
    done1     = (state == DONE) && owner;
    stb0      = burst_stb && !owner;
    stb1      = burst_stb && owner;
    ufm_stall = (state == BURST) && (owner ? stall1 : stall0);
    data      = ufm_data;
  end

endmodule

// File: tb/tb_ufm_arbiter.sv
// Scoreboard bench for ufm_arbiter with a behavioural ufm_reader model.
// Define UFM_ARB_TIMEOUT_EN to also exercise the timeout path (TIMEOUT=64).
module tb_ufm_arbiter;
  localparam int PB = 16;
  localparam int AW = 11;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, stall0, stall1;
  logic [AW-1:0] addr0, addr1;
  logic          gnt0, gnt1, stb0, stb1, done0, done1, busy;
  logic [7:0]    data, ufm_data;
  logic          ufm_start, ufm_stall, ufm_data_stb, ufm_ready;
  logic [AW-1:0] ufm_addr;
`ifdef UFM_ARB_TIMEOUT_EN
  logic          err;
`endif

  always #5 clk = ~clk;

  ufm_arbiter #(
    .PAGE_BYTES(PB),
    .ADDR_W(AW)
`ifdef UFM_ARB_TIMEOUT_EN
    , .TIMEOUT(TO)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .stall0(stall0), .gnt0(gnt0), .stb0(stb0), .done0(done0),
    .req1(req1), .addr1(addr1), .stall1(stall1), .gnt1(gnt1), .stb1(stb1), .done1(done1),
    .data(data), .busy(busy),
`ifdef UFM_ARB_TIMEOUT_EN
    .err(err),
`endif
    .ufm_start(ufm_start), .ufm_addr(ufm_addr), .ufm_stall(ufm_stall),
    .ufm_data(ufm_data), .ufm_data_stb(ufm_data_stb), .ufm_ready(ufm_ready)
  );

  // ---------------- ufm_reader model: PB bytes, data = base + index -------
  logic       rd_busy, rd_stb, ready_en, halt, stray;
  int         rd_idx;
  logic [7:0] rd_base;

  assign ufm_ready    = ready_en & ~rd_busy;
  assign rd_stb       = rd_busy & ~ufm_stall & ~halt;
  assign ufm_data_stb = rd_stb | stray;
  assign ufm_data     = rd_base + 8'(rd_idx);

  always @(posedge clk) begin
    if (rst) begin
      rd_busy <= 1'b0; rd_idx <= 0; rd_base <= 8'h00;
    end else if (ufm_start) begin
      rd_busy <= 1'b1; rd_idx <= 0; rd_base <= ufm_addr[7:0];
    end else if (rd_stb) begin
      rd_idx <= rd_idx + 1;
      if (rd_idx == PB - 1) rd_busy <= 1'b0;
    end
  end

  // ---------------- scoreboard types and queues ---------------------------
  typedef enum int {EV_GNT, EV_STB, EV_DONE} ev_k;
  typedef struct {ev_k k; logic who; logic [10:0] val;} ev_t;
  typedef enum int {P_GNT0, P_GNT1, P_BUSY, P_START, P_ADDR, P_STALL,
                    P_DONE0, P_DONE1, P_STB0, P_STB1, P_ERR, P_BOUND} pk;
  typedef struct {pk k; logic [10:0] exp; string name;} pr_t;

  ev_t exq[$];
  pr_t prq[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  logic fin = 1'b0;
  logic expect_to = 1'b0;
  int  hold0 = 0, hold1 = 0;

  // ---------------- monitor: the only process that compares --------------
  int   cyc = 0, last_stb_cyc = 0;
  logic prev_done = 1'b0;

  function automatic void chk(string nm, logic [10:0] act, logic [10:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void unexpected(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT event with no expectation queued (cycle %0d)", nm, cyc);
  endfunction

  always @(negedge clk) begin
    pr_t p;
    ev_t e;
    logic [10:0] act;
    cyc++;
    while (prq.size() != 0) begin
      p = prq.pop_front();
      act = '0;
      case (p.k)
        P_GNT0:  act = {10'b0, gnt0};
        P_GNT1:  act = {10'b0, gnt1};
        P_BUSY:  act = {10'b0, busy};
        P_START: act = {10'b0, ufm_start};
        P_ADDR:  act = ufm_addr;
        P_STALL: act = {10'b0, ufm_stall};
        P_DONE0: act = {10'b0, done0};
        P_DONE1: act = {10'b0, done1};
        P_STB0:  act = {10'b0, stb0};
        P_STB1:  act = {10'b0, stb1};
`ifdef UFM_ARB_TIMEOUT_EN
        P_ERR:   act = {10'b0, err};
`endif
        default: act = '0;
      endcase
      if (p.k == P_BOUND) unexpected(p.name);
      else chk(p.name, act, p.exp);
    end
    if (ufm_start) begin
      if (exq.size() == 0) unexpected("grant");
      else begin
        e = exq.pop_front();
        chk("grant_kind", 11'(EV_GNT), 11'(e.k));
        chk("grant_owner", {9'b0, gnt0, gnt1}, e.who ? 11'b01 : 11'b10);
        chk("grant_addr", ufm_addr, e.val);
      end
    end
    if (stb0 || stb1) begin
      if (exq.size() == 0) unexpected("strobe");
      else begin
        e = exq.pop_front();
        chk("stb_kind", 11'(EV_STB), 11'(e.k));
        chk("stb_route", {9'b0, stb0, stb1}, e.who ? 11'b01 : 11'b10);
        chk("stb_data", {3'b0, data}, e.val);
      end
      last_stb_cyc = cyc;
    end
    if (done0 || done1) begin
      if (exq.size() == 0) unexpected("done");
      else begin
        e = exq.pop_front();
        chk("done_kind", 11'(EV_DONE), 11'(e.k));
        chk("done_who", {9'b0, done0, done1}, e.who ? 11'b01 : 11'b10);
        chk("done_gnt_busy", {9'b0, e.who ? gnt1 : gnt0, busy}, 11'b11);
        chk("done_latency", 11'(cyc - last_stb_cyc), expect_to ? 11'(TO + 1) : 11'd1);
      end
    end
    if (prev_done) chk("release", {8'b0, gnt0, gnt1, busy}, 11'b0);
    prev_done = done0 | done1;
    if (fin) begin
      if (exq.size() != 0) unexpected("leftover_expectations");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(pk k, logic [10:0] e, string n);
    pr_t p;
    p.k = k; p.exp = e; p.name = n;
    prq.push_back(p);
  endtask

  task automatic push_ev(ev_k k, logic who, logic [10:0] v);
    ev_t e;
    e.k = k; e.who = who; e.val = v;
    exq.push_back(e);
  endtask

  task automatic exp_burst(logic who, logic [10:0] a, int nbytes);
    logic [7:0] b;
    push_ev(EV_GNT, who, a);
    for (int i = 0; i < nbytes; i++) begin
      b = a[7:0] + 8'(i);
      push_ev(EV_STB, who, {3'b0, b});
    end
    push_ev(EV_DONE, who, 11'd0);
  endtask

  // Requesters keep req high until their done pulse for the last held burst.
  task automatic run(int maxc);
    int n = 0;
    while (!(exq.size() == 0 && hold0 == 0 && hold1 == 0 && !busy)) begin
      tick();
      n++;
      if (done0 && hold0 > 0) hold0--;
      if (done1 && hold1 > 0) hold1--;
      req0 = (hold0 > 0);
      req1 = (hold1 > 0);
      if (n > maxc) begin
        probe(P_BOUND, '0, "run_cycle_budget");
        exq.delete();
        hold0 = 0; hold1 = 0; req0 = 1'b0; req1 = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_q(int sz, int maxc);
    int n = 0;
    while (exq.size() > sz) begin
      tick();
      n++;
      if (n > maxc) begin
        probe(P_BOUND, '0, "wait_cycle_budget");
        break;
      end
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- directed stimulus -------------------------------------
  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; stall0 = 1'b0; stall1 = 1'b0;
    addr0 = '0; addr1 = '0; ready_en = 1'b1; halt = 1'b0; stray = 1'b0;
    tick(); tick();
    probe(P_GNT0, 0, "rst_gnt0");   probe(P_GNT1, 0, "rst_gnt1");
    probe(P_BUSY, 0, "rst_busy");   probe(P_START, 0, "rst_start");
    probe(P_ADDR, 0, "rst_addr");   probe(P_DONE0, 0, "rst_done0");
    probe(P_DONE1, 0, "rst_done1"); probe(P_STALL, 0, "rst_stall");
    tick();
    rst = 1'b0;

    // Single requester, top-of-range address.
    addr0 = 11'd2042; hold0 = 1; req0 = 1'b1;
    probe(P_GNT0, 0, "t1_gnt0_before");
    exp_burst(1'b0, 11'd2042, PB);
    tick();
    probe(P_GNT0, 1, "t1_gnt0"); probe(P_START, 1, "t1_start"); probe(P_ADDR, 11'd2042, "t1_addr");
    tick();
    probe(P_START, 0, "t1_start_one_cycle");
    run(100);
    // Idle: address held, stall not forwarded, stray strobe dropped.
    stall0 = 1'b1; stray = 1'b1;
    probe(P_ADDR, 11'd2042, "idle_addr_hold"); probe(P_STALL, 0, "idle_stall");
    probe(P_STB0, 0, "idle_stray_stb0");       probe(P_STB1, 0, "idle_stray_stb1");
    tick();
    stall0 = 1'b0; stray = 1'b0;

    // Simultaneous requests after reset: requester 0 first.
    pulse_rst();
    addr0 = 11'd5; addr1 = 11'd9; hold0 = 1; hold1 = 1; req0 = 1'b1; req1 = 1'b1;
    exp_burst(1'b0, 11'd5, PB);
    exp_burst(1'b1, 11'd9, PB);
    run(200);

    // Both held for four bursts: 0,1,0,1 alternation, data base wraps at 0xFF.
    pulse_rst();
    addr0 = 11'h100; addr1 = 11'h2FF; hold0 = 2; hold1 = 2; req0 = 1'b1; req1 = 1'b1;
    exp_burst(1'b0, 11'h100, PB); exp_burst(1'b1, 11'h2FF, PB);
    exp_burst(1'b0, 11'h100, PB); exp_burst(1'b1, 11'h2FF, PB);
    run(400);

    // Reader not ready: no grant until ufm_ready rises.
    addr1 = 11'h0AB; ready_en = 1'b0; hold1 = 1; req1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      probe(P_GNT1, 0, "t4_no_gnt"); probe(P_START, 0, "t4_no_start");
    end
    ready_en = 1'b1;
    probe(P_GNT1, 0, "t4_gnt_not_yet");
    exp_burst(1'b1, 11'h0AB, PB);
    tick();
    probe(P_GNT1, 1, "t4_gnt1"); probe(P_START, 1, "t4_start");
    run(100);

    // Stall forwarded mid-burst; byte sequence resumes where it stopped.
    addr1 = 11'h033; hold1 = 1; req1 = 1'b1;
    exp_burst(1'b1, 11'h033, PB);
    wait_q(12, 50);
    stall1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      probe(P_STALL, 1, "t5_stall_fwd"); probe(P_STB1, 0, "t5_no_stb");
      tick();
    end
    stall1 = 1'b0;
    probe(P_STALL, 0, "t5_stall_released");
    run(100);

    // Reset mid-burst, then a full fresh burst.
    addr1 = 11'h044; hold1 = 1; req1 = 1'b1;
    exp_burst(1'b1, 11'h044, PB);
    wait_q(12, 50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exq.delete();
    probe(P_GNT1, 0, "t5_rst_gnt1"); probe(P_BUSY, 0, "t5_rst_busy");
    probe(P_ADDR, 0, "t5_rst_addr"); probe(P_START, 0, "t5_rst_start");
    exp_burst(1'b1, 11'h044, PB);
    run(100);

`ifdef UFM_ARB_TIMEOUT_EN
    // Reader goes silent after 3 bytes: timeout releases the grant, err sticks.
    pulse_rst();
    addr0 = 11'h070; hold0 = 1; req0 = 1'b1; expect_to = 1'b1;
    exp_burst(1'b0, 11'h070, 3);
    probe(P_ERR, 0, "to_err_clear");
    wait_q(1, 50);
    halt = 1'b1;
    run(200);
    probe(P_ERR, 1, "to_err_set");
    tick();
    probe(P_ERR, 1, "to_err_sticky");
    expect_to = 1'b0;
    halt = 1'b0;
    pulse_rst();
    probe(P_ERR, 0, "to_err_rst");
    tick();
`endif

    fin = 1'b1;
    tick();
    tick();
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
